mux_n_rr_reg: RTL and testbench

//   Parametrised N-input, WIDTH-bit multiplexer with a registered, valid/ready-handshaked output.

---
 rtl/mux_n_rr_reg_if.sv | 29 ++
 rtl/mux_n_rr_reg.sv | 131 +++++++++++++
 tb/tb_mux_n_rr_reg.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_rr_reg_if.sv
// Bundle of the producer-side and consumer-side handshake signals of the
// N-input registered multiplexer. The master modport is the environment
// (producers plus consumer); the slave modport is the multiplexer itself.
interface mux_n_rr_reg_if #(
    parameter int N     = 4,
    parameter int WIDTH = 2
);
    localparam int SEL_W = $clog2(N);

    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_src;
    logic                 out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_n_rr_reg.sv
// N-input, WIDTH-bit multiplexer with a one-deep registered output stage.
// Channel choice is either a fixed index (mode=0) or round-robin starting
// at rr_ptr (mode=1). The output register refills in the same cycle it is
// drained, so a continuously ready consumer sees one word per cycle.
module mux_n_rr_reg #(
    parameter int N     = 4,
    parameter int WIDTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_n_rr_reg_if.slave  bus
);
    localparam int SEL_W = $clog2(N);

    logic                 load_en_s;
    logic                 grant_vld_s;
    logic [SEL_W-1:0]     grant_idx_s;
    logic [WIDTH-1:0]     sel_data_s;
    logic [N-1:0]         in_ready_s;

    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [WIDTH-1:0]     out_data_q;
    logic [WIDTH-1:0]     out_data_d;
    logic [SEL_W-1:0]     out_src_q;
    logic [SEL_W-1:0]     out_src_d;
    logic [SEL_W-1:0]     rr_ptr_q;
    logic [SEL_W-1:0]     rr_ptr_d;

    // The output register may take a new word when it is empty or being drained.
    assign load_en_s = !out_valid_q || bus.out_ready;

    // Grant selection: fixed index (out-of-range sel never grants) or the first
    // valid channel at or after rr_ptr, wrapping modulo N.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        if (bus.mode == 1'b0) begin
            for (int i = 0; i < N; i++) begin
                if ((bus.sel == SEL_W'(i)) && bus.in_valid[i]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SEL_W'(i);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest valid channel wins.
            for (int k = N - 1; k >= 0; k--) begin
                for (int i = 0; i < N; i++) begin
                    if (((int'(rr_ptr_q) + k == i) || (int'(rr_ptr_q) + k == i + N)) &&
                        bus.in_valid[i]) begin
                        grant_vld_s = 1'b1;
                        grant_idx_s = SEL_W'(i);
                    end else begin
                        grant_vld_s = grant_vld_s;
                    end
                end
            end
        end
    end

    // Data path: pick the granted channel's word from the packed input bus.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx_s == SEL_W'(i)) begin
                sel_data_s = bus.in_data[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Per-channel accept: one-hot on the granted channel, forced low during reset.
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < N; i++) begin
            if (rst_n && load_en_s && grant_vld_s && (grant_idx_s == SEL_W'(i))) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en_s) begin
            if (grant_vld_s) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data_s;
                out_src_d   = grant_idx_s;
                if (bus.mode) begin
                    rr_ptr_d = (grant_idx_s == SEL_W'(N - 1)) ? '0 : grant_idx_s + SEL_W'(1);
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
            end else begin
                // Drained with nothing to replace it: data and source keep their last value.
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any held word and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux_n_rr_reg.sv
// Bench for mux_n_rr_reg: directed scenarios on N=4/WIDTH=2 and N=3/WIDTH=2
// instances, then randomized traffic on an N=5/WIDTH=8 instance checked every
// cycle against a behavioural model with an in-order scoreboard.
module tb_mux_n_rr_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mux_n_rr_reg_if #(.N(4), .WIDTH(2)) if4 ();
    mux_n_rr_reg_if #(.N(3), .WIDTH(2)) if3 ();
    mux_n_rr_reg_if #(.N(5), .WIDTH(8)) if5 ();

    mux_n_rr_reg #(.N(4), .WIDTH(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mux_n_rr_reg #(.N(3), .WIDTH(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    mux_n_rr_reg #(.N(5), .WIDTH(8)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-level grant rule: returns channel index or -1 for no grant.
    function automatic int model_grant(input int n, input bit md, input int s,
                                       input int ptr, input logic [7:0] v);
        if (!md) begin
            if (s < n && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (ptr + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Behavioural model of the N=5 instance.
    bit       m_valid = 1'b0;
    int       m_data  = 0;
    int       m_src   = 0;
    int       m_ptr   = 0;
    int       q_data[$];
    int       q_src[$];

    // Model update at each active edge from the inputs presented in the previous cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 0;
            m_src   <= 0;
            m_ptr   <= 0;
            q_data.delete();
            q_src.delete();
        end else begin
            automatic bit ld = !m_valid || if5.out_ready;
            automatic int g  = model_grant(5, if5.mode, int'(if5.sel), m_ptr, 8'(if5.in_valid));
            if (ld) begin
                if (g >= 0) begin
                    m_valid <= 1'b1;
                    m_data  <= int'(if5.in_data[g*8 +: 8]);
                    m_src   <= g;
                    if (if5.mode) m_ptr <= (g + 1) % 5;
                    q_data.push_back(int'(if5.in_data[g*8 +: 8]));
                    q_src.push_back(g);
                end else begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

    // Compare process: checks the N=5 instance mid-cycle against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            automatic bit ld = !m_valid || if5.out_ready;
            automatic int g  = model_grant(5, if5.mode, int'(if5.sel), m_ptr, 8'(if5.in_valid));
            automatic logic [4:0] erdy = 5'b00000;
            if (ld && g >= 0) erdy[g] = 1'b1;
            chk("rnd_in_ready", if5.in_ready, erdy);
            chk("rnd_out_valid", if5.out_valid, m_valid);
            if (m_valid) begin
                chk("rnd_out_data", if5.out_data, m_data);
                chk("rnd_out_src", if5.out_src, m_src);
            end
            if (if5.out_valid && if5.out_ready) begin
                if (q_data.size() == 0) begin
                    chk("sb_unexpected_word", 1, 0);
                end else begin
                    chk("sb_data_order", if5.out_data, q_data.pop_front());
                    chk("sb_src_order", if5.out_src, q_src.pop_front());
                end
            end
        end
    end

    initial begin
        if4.mode = 1'b0; if4.sel = '0; if4.in_valid = '0; if4.in_data = '0; if4.out_ready = 1'b0;
        if3.mode = 1'b0; if3.sel = '0; if3.in_valid = '0; if3.in_data = '0; if3.out_ready = 1'b0;
        if5.mode = 1'b0; if5.sel = '0; if5.in_valid = '0; if5.in_data = '0; if5.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        chk("rst_out_valid", if4.out_valid, 0);
        chk("rst_out_data", if4.out_data, 0);
        chk("rst_out_src", if4.out_src, 0);
        chk("rst_in_ready", if4.in_ready, 0);

        // Model pins.
        chk("pin_rr_wrap", model_grant(4, 1'b1, 0, 2, 8'b0000_1001), 3);
        chk("pin_sel_oob", model_grant(3, 1'b0, 3, 0, 8'b0000_0111), -1);
        chk("pin_rr_mod5", model_grant(5, 1'b1, 0, 4, 8'b0000_0001), 0);

        // Fixed mode: ch0=00 ch1=01 ch2=10 ch3=11.
        step();
        if4.mode = 1'b0; if4.sel = 2'd2; if4.in_valid = 4'b1111;
        if4.in_data = 8'b11_10_01_00; if4.out_ready = 1'b1;
        #1 chk("fix_in_ready", if4.in_ready, 4'b0100);
        step();
        chk("fix_out_valid", if4.out_valid, 1);
        chk("fix_out_data", if4.out_data, 2'b10);
        chk("fix_out_src", if4.out_src, 2);

        // Round robin with all channels valid, pointer still 0.
        if4.mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_seq_src", if4.out_src, k % 4);
            chk("rr_seq_data", if4.out_data, k % 4);
        end
        if4.in_valid = 4'b1001;
        #1 chk("rr_1001_ready", if4.in_ready, 4'b1000);
        step();
        chk("rr_1001_src3", if4.out_src, 3);
        chk("rr_1001_ready2", if4.in_ready, 4'b0001);
        step();
        chk("rr_1001_src0", if4.out_src, 0);

        // Back-pressure, pointer now 1.
        if4.out_ready = 1'b0; if4.in_valid = 4'b1111;
        #1 chk("bp_in_ready0", if4.in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_out_valid", if4.out_valid, 1);
            chk("bp_out_src", if4.out_src, 0);
            chk("bp_out_data", if4.out_data, 0);
            chk("bp_in_ready", if4.in_ready, 0);
        end
        if4.out_ready = 1'b1;
        #1 chk("bp_release_ready", if4.in_ready, 4'b0010);
        step();
        chk("bp_next_valid", if4.out_valid, 1);
        chk("bp_next_src", if4.out_src, 1);
        chk("bp_next_data", if4.out_data, 1);

        // No valid in round robin: pointer (2) holds, output drains.
        if4.in_valid = 4'b0000;
        step();
        chk("idle_out_valid", if4.out_valid, 0);
        chk("idle_src_hold", if4.out_src, 1);
        step();
        step();
        if4.in_valid = 4'b1111;
        #1 chk("idle_ptr_hold", if4.in_ready, 4'b0100);
        step();
        chk("idle_resume_src", if4.out_src, 2);

        // Mode flip 1->0 follows sel; flip back keeps pointer 3.
        if4.mode = 1'b0; if4.sel = 2'd1;
        #1 chk("flip_sel_ready", if4.in_ready, 4'b0010);
        step();
        chk("flip_sel_src", if4.out_src, 1);
        if4.mode = 1'b1;
        #1 chk("flip_back_ready", if4.in_ready, 4'b1000);
        step();
        chk("flip_back_src", if4.out_src, 3);
        chk("flip_back_data", if4.out_data, 3);

        // Reset mid-stream with a held word.
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", if4.out_valid, 0);
        chk("midrst_out_data", if4.out_data, 0);
        chk("midrst_out_src", if4.out_src, 0);
        chk("midrst_in_ready", if4.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_ptr_zero", if4.in_ready, 4'b0001);
        if4.in_valid = 4'b0000;

        // N=3: out-of-range sel never grants.
        step();
        if3.mode = 1'b0; if3.sel = 2'd0; if3.in_valid = 3'b111;
        if3.in_data = 6'b10_01_11; if3.out_ready = 1'b1;
        step();
        chk("n3_out_valid", if3.out_valid, 1);
        chk("n3_out_src", if3.out_src, 0);
        chk("n3_out_data", if3.out_data, 3);
        if3.sel = 2'd3;
        #1 chk("n3_oob_ready", if3.in_ready, 0);
        step();
        chk("n3_oob_valid", if3.out_valid, 0);
        chk("n3_oob_src_hold", if3.out_src, 0);
        chk("n3_oob_data_hold", if3.out_data, 3);
        if3.in_valid = 3'b000;

        // Randomized traffic on the N=5, WIDTH=8 instance.
        step();
        chk_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) if5.mode = ~if5.mode;
            if5.sel       = 3'($urandom_range(0, 7));
            if5.in_valid  = 5'($urandom);
            if5.in_data   = 40'({$urandom(), $urandom()});
            if5.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
